// File: rtl/tama_pkg.sv
// tama_pkg: command byte constants shared by the UART command front-end and
// the stats block, plus helpers to case-fold a received byte and to test it
// against the pet command set.
package tama_pkg;

  localparam logic [7:0] CMD_NONE  = 8'h00;
  localparam logic [7:0] CMD_EAT   = 8'h65;  // 'e'
  localparam logic [7:0] CMD_PLAY  = 8'h70;  // 'p'
  localparam logic [7:0] CMD_BATH  = 8'h62;  // 'b'
  localparam logic [7:0] CMD_SLEEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_TALK  = 8'h74;  // 't'
  localparam logic [7:0] CMD_WAKE  = 8'h77;  // 'w'

  // Uppercase ASCII letters map onto lowercase; every other byte is untouched.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    logic [7:0] r;
    if ((b >= 8'h41) && (b <= 8'h5A)) begin
      r = b | 8'h20;
    end else begin
      r = b;
    end
    return r;
  endfunction

  // True for the six pet commands (expects an already folded byte).
  function automatic logic is_cmd(input logic [7:0] b);
    logic r;
    case (b)
      CMD_EAT, CMD_PLAY, CMD_BATH, CMD_SLEEP, CMD_TALK, CMD_WAKE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop synchronizer plus 8N1 receive FSM.
// Ports:
//   clk, reset (async active-low), rx (raw UART line, idle high)
//   data_o      - shift register contents; a complete byte while strobe_o is high
//   strobe_o    - high in the stop-bit sample cycle when the stop bit is high
//   frame_err_o - high in the stop-bit sample cycle when the stop bit is low
// strobe_o/frame_err_o are decoded from registered state; the top level
// registers them together with its command logic.
module uart_rx_core
  import tama_pkg::*;
#(
  parameter int CPB = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       strobe_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CPB);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          rxs_s, expire_s, strobe_s, ferr_s;

  assign rxs_s = sync2_q;
  // A load of N expires on the N-th cycle, so a load of CPB spaces samples CPB apart.
  assign expire_s = (cnt_q == CW'(1'b1));

  // Synchronizer and receive FSM state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  // Receive FSM next-state and sample logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    strobe_s = 1'b0;
    ferr_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_s) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (expire_s) begin
          if (rxs_s) begin
            state_d = S_IDLE;  // glitch, not a start bit
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      S_DATA: begin
        if (expire_s) begin
          shift_d = {rxs_s, shift_q[7:1]};  // LSB first
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      S_STOP: begin
        if (expire_s) begin
          if (rxs_s) begin
            strobe_s = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must return high before a new frame can start.
        if (rxs_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_o      = shift_q;
  assign strobe_o    = strobe_s;
  assign frame_err_o = ferr_s;

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART command front-end for the tamagotchi core.
// Ports:
//   clk, reset (async active-low), rx (UART line)
//   cmd       - folded command byte held HOLD_CYCLES, then 0x00 for >= GAP_CYCLES
//   rx_byte   - last correctly framed byte (unfiltered)
//   rx_strobe - one-cycle pulse when rx_byte updates
//   frame_err - one-cycle pulse on a low stop bit
//   overrun   - one-cycle pulse when a pending command is replaced
module uart_cmd_rx
  import tama_pkg::*;
#(
  parameter int CLK_HZ      = 27000000,
  parameter int BAUD        = 115200,
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] O_IDLE = 2'd0;
  localparam logic [1:0] O_HOLD = 2'd1;
  localparam logic [1:0] O_GAP  = 2'd2;

  logic [7:0]    core_data_s, folded_s;
  logic          core_strobe_s, core_ferr_s, new_valid_s, t_expire_s;
  logic [1:0]    ostate_q, ostate_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    cmd_q, cmd_d, rx_byte_q, rx_byte_d, pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          rx_strobe_q, rx_strobe_d, frame_err_q, frame_err_d, overrun_q, overrun_d;

  uart_rx_core #(.CPB(CPB)) u_core (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_o     (core_data_s),
    .strobe_o   (core_strobe_s),
    .frame_err_o(core_ferr_s)
  );

  assign folded_s    = fold_case(core_data_s);
  assign new_valid_s = core_strobe_s && is_cmd(folded_s);
  assign t_expire_s  = (tcnt_q == TW'(1'b1));

  // Output FSM, pending slot and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ostate_q    <= O_IDLE;
      tcnt_q      <= '0;
      cmd_q       <= CMD_NONE;
      rx_byte_q   <= 8'h00;
      pend_q      <= CMD_NONE;
      pend_v_q    <= 1'b0;
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ostate_q    <= ostate_d;
      tcnt_q      <= tcnt_d;
      cmd_q       <= cmd_d;
      rx_byte_q   <= rx_byte_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      rx_strobe_q <= rx_strobe_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Command filter, hold/gap sequencing and one-deep pending slot.
  always_comb begin
    ostate_d    = ostate_q;
    tcnt_d      = tcnt_q;
    cmd_d       = cmd_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    overrun_d   = 1'b0;
    rx_strobe_d = core_strobe_s;
    frame_err_d = core_ferr_s;
    if (core_strobe_s) begin
      rx_byte_d = core_data_s;
    end else begin
      rx_byte_d = rx_byte_q;
    end
    case (ostate_q)
      O_IDLE: begin
        // A fresh byte beats a pending one; either way the slot empties.
        if (new_valid_s) begin
          cmd_d    = folded_s;
          tcnt_d   = TW'(HOLD_CYCLES);
          ostate_d = O_HOLD;
          pend_v_d = 1'b0;
        end else if (pend_v_q) begin
          cmd_d    = pend_q;
          tcnt_d   = TW'(HOLD_CYCLES);
          ostate_d = O_HOLD;
          pend_v_d = 1'b0;
        end else begin
          ostate_d = O_IDLE;
        end
      end
      O_HOLD: begin
        if (t_expire_s) begin
          cmd_d    = CMD_NONE;
          tcnt_d   = TW'(GAP_CYCLES);
          ostate_d = O_GAP;
        end else begin
          tcnt_d = tcnt_q - TW'(1'b1);
        end
      end
      O_GAP: begin
        if (t_expire_s) begin
          ostate_d = O_IDLE;
        end else begin
          tcnt_d = tcnt_q - TW'(1'b1);
        end
      end
      default: begin
        ostate_d = O_IDLE;
        cmd_d    = CMD_NONE;
      end
    endcase
    if (((ostate_q == O_HOLD) || (ostate_q == O_GAP)) && new_valid_s) begin
      pend_d    = folded_s;
      pend_v_d  = 1'b1;
      overrun_d = pend_v_q;
    end else begin
      overrun_d = 1'b0;
    end
  end

  assign cmd       = cmd_q;
  assign rx_byte   = rx_byte_q;
  assign rx_strobe = rx_strobe_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx. A second instance with a long hold time is
// used for the back-to-back/overrun scenario, since at CPB=10 a frame lasts
// 100 cycles and could not overlap a 20-cycle hold.
module tb_uart_cmd_rx;
  import tama_pkg::*;

  localparam int CPB   = 10;
  localparam int HOLD  = 20;
  localparam int GAP   = 4;
  localparam int HOLD2 = 250;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic rx2   = 1'b1;
  logic [7:0] cmd, rx_byte, cmd2, rx_byte2;
  logic rx_strobe, frame_err, overrun, rx_strobe2, frame_err2, overrun2;

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLK_HZ(1000000), .BAUD(100000), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .rx(rx), .cmd(cmd), .rx_byte(rx_byte),
    .rx_strobe(rx_strobe), .frame_err(frame_err), .overrun(overrun)
  );

  uart_cmd_rx #(.CLK_HZ(1000000), .BAUD(100000), .HOLD_CYCLES(HOLD2), .GAP_CYCLES(GAP)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .cmd(cmd2), .rx_byte(rx_byte2),
    .rx_strobe(rx_strobe2), .frame_err(frame_err2), .overrun(overrun2)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_byte_q[$];
  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_cmd2_q[$];
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_ovr2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got event with value %0h expected no event", name, act);
  endtask

  // Monitor state per instance (index 0 = dut, 1 = dut2).
  logic [7:0] prev_cmd[2];
  int run_len[2];
  int gap_len[2];
  bit seen_hold[2];

  always @(negedge clk) begin
    logic [7:0] c;
    int hl;
    if (!reset) begin
      check("cmd_in_reset", cmd, 8'h00);
      check("cmd2_in_reset", cmd2, 8'h00);
      check("rx_byte_in_reset", rx_byte, 8'h00);
      for (int d = 0; d < 2; d++) begin
        prev_cmd[d] = 8'h00;
        run_len[d] = 0;
        gap_len[d] = 0;
        seen_hold[d] = 1'b0;
      end
    end else begin
      if (rx_strobe) begin
        if (exp_byte_q.size() == 0) fail_unexpected("rx_strobe", rx_byte);
        else check("rx_byte", rx_byte, exp_byte_q.pop_front());
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (overrun2) n_ovr2++;
      for (int d = 0; d < 2; d++) begin
        c  = (d == 0) ? cmd : cmd2;
        hl = (d == 0) ? HOLD : HOLD2;
        if (c != prev_cmd[d]) begin
          if (prev_cmd[d] == 8'h00) begin
            if (d == 0) begin
              if (exp_cmd_q.size() == 0) fail_unexpected("cmd_rise", c);
              else check("cmd_value", c, exp_cmd_q.pop_front());
            end else begin
              if (exp_cmd2_q.size() == 0) fail_unexpected("cmd2_rise", c);
              else check("cmd2_value", c, exp_cmd2_q.pop_front());
            end
            if (seen_hold[d]) check("gap_at_least_min", (gap_len[d] >= GAP), 1);
            run_len[d] = 1;
          end else if (c == 8'h00) begin
            check((d == 0) ? "hold_len" : "hold2_len", run_len[d], hl);
            gap_len[d] = 1;
            seen_hold[d] = 1'b1;
          end else begin
            fail_unexpected("cmd_change_without_gap", c);
            run_len[d] = 1;
          end
        end else if (c != 8'h00) begin
          run_len[d]++;
        end else begin
          gap_len[d]++;
        end
        prev_cmd[d] = c;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input bit to2, input logic v);
    if (to2) rx2 = v;
    else rx = v;
  endtask

  // One 8N1 frame; stop_low_bits > 0 holds the stop bit low that many bit-times.
  task automatic send(input logic [7:0] b, input int stop_low_bits, input bit to2);
    @(negedge clk);
    set_line(to2, 1'b0);
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(to2, b[i]);
      idle(CPB);
    end
    if (stop_low_bits > 0) begin
      set_line(to2, 1'b0);
      idle(stop_low_bits * CPB);
      set_line(to2, 1'b1);
      idle(2 * CPB);
    end else begin
      set_line(to2, 1'b1);
      idle(CPB - 1);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    idle(3);
    check("reset_cmd", cmd, 8'h00);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_pulses", {rx_strobe, frame_err, overrun}, 3'b000);
    reset = 1'b1;
    idle(10);

    // 1: plain lowercase command
    exp_byte_q.push_back(8'h65); exp_cmd_q.push_back(8'h65);
    send(8'h65, 0, 1'b0);
    idle(40);

    // 2: uppercase folds; non-command strobes but leaves cmd alone
    exp_byte_q.push_back(8'h45); exp_cmd_q.push_back(8'h65);
    send(8'h45, 0, 1'b0);
    idle(40);
    exp_byte_q.push_back(8'h41);
    send(8'h41, 0, 1'b0);
    idle(40);
    check("cmd_after_A", cmd, 8'h00);

    // 3: back-to-back on the long-hold instance; 0x62 is overwritten by 0x74
    exp_cmd2_q.push_back(8'h70); exp_cmd2_q.push_back(8'h74);
    send(8'h70, 0, 1'b1);
    send(8'h62, 0, 1'b1);
    send(8'h74, 0, 1'b1);
    idle(450);
    check("overrun2_count", n_ovr2, 1);
    check("cmd2_queue_drained", exp_cmd2_q.size(), 0);

    // 4: long-low stop bit, then a good frame
    send(8'h73, 3, 1'b0);
    idle(20);
    check("frame_err_count", n_ferr, 1);
    check("cmd_after_ferr", cmd, 8'h00);
    exp_byte_q.push_back(8'h77); exp_cmd_q.push_back(8'h77);
    send(8'h77, 0, 1'b0);
    idle(40);

    // 5: short glitch is a false start
    @(negedge clk); rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    check("frame_err_after_glitch", n_ferr, 1);
    exp_byte_q.push_back(8'h62); exp_cmd_q.push_back(8'h62);
    send(8'h62, 0, 1'b0);
    idle(40);

    // 6a: reset in the middle of a data phase
    @(negedge clk); rx = 1'b0;
    idle(CPB);
    rx = 1'b1; idle(CPB);
    rx = 1'b0; idle(CPB);
    #2 reset = 1'b0;
    rx = 1'b1;
    #1 check("cmd_reset_mid_data", cmd, 8'h00);
    idle(3);
    reset = 1'b1;
    idle(30);

    // 6b: reset while a command is held
    exp_byte_q.push_back(8'h74); exp_cmd_q.push_back(8'h74);
    send(8'h74, 0, 1'b0);
    idle(5);
    check("cmd_before_reset", cmd, 8'h74);
    #2 reset = 1'b0;
    #1 check("cmd_reset_mid_hold", cmd, 8'h00);
    idle(3);
    reset = 1'b1;
    idle(10);
    exp_byte_q.push_back(8'h74); exp_cmd_q.push_back(8'h74);
    send(8'h74, 0, 1'b0);
    idle(40);

    check("byte_queue_drained", exp_byte_q.size(), 0);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("overrun_count", n_ovr, 0);
    check("frame_err_final", n_ferr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
